// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch: PC register, next-PC select and IF/ID pipeline register.
// Optional IF_FETCH_COUNT_EN adds a fetch_count output.  Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_bubble;
  logic        w_load;

  assign imem_addr  = r_pc;
  assign w_pc_plus4 = r_pc + 32'd4;

  // Redirects beat stall; the jump region comes from the instruction now in decode.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (branch_taken)
      w_next_pc = {branch_target[31:2], 2'b00};
    else if (jump)
      w_next_pc = {if_id_pc4[31:28], jump_index, 2'b00};
    else if (stall)
      w_next_pc = r_pc;
  end

  assign w_bubble = branch_taken | jump | flush;
  assign w_load   = ~w_bubble & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (w_bubble) begin
        if_id_instr <= 32'h0;
        if_id_pc4   <= 32'h0;
        if_id_valid <= 1'b0;
      end else if (w_load) begin
        if_id_instr <= imem_instr;
        if_id_pc4   <= w_pc_plus4;
        if_id_valid <= 1'b1;
      end
    end
  end

`ifdef IF_FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      fetch_count <= 32'h0;
    else if (w_load)
      fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios then random
// stimulus compared against a behavioural pipeline model.
`default_nettype none

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken, jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] imem_addr, imem_instr;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  logic [31:0] mem [256];
  assign imem_instr = mem[imem_addr[9:2]];

  instruction_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef IF_FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the fetch stage state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 32'h0; jump_index = 26'h0;
  endtask

  // One clock edge: predict from the pre-edge inputs/state, then compare.
  task automatic tick();
    logic [31:0] n_pc, n_instr, n_pc4, n_cnt;
    logic        n_valid;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; n_cnt = m_cnt;
    if (rst) begin
      n_pc = 32'h0; n_instr = 0; n_pc4 = 0; n_valid = 0; n_cnt = 0;
    end else if (branch_taken || jump) begin
      n_pc = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                          : ((m_pc4 & 32'hF000_0000) | ({6'b0, jump_index} << 2));
      n_instr = 0; n_pc4 = 0; n_valid = 0;
    end else if (flush) begin
      n_pc = stall ? m_pc : m_pc + 4;
      n_instr = 0; n_pc4 = 0; n_valid = 0;
    end else if (!stall) begin
      n_instr = mem[m_pc[9:2]]; n_pc4 = m_pc + 4; n_valid = 1;
      n_pc = m_pc + 4; n_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_cnt = n_cnt;
    chk("model imem_addr", imem_addr, m_pc);
    chk("model if_id_instr", if_id_instr, m_instr);
    chk("model if_id_pc4", if_id_pc4, m_pc4);
    chk("model if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
`ifdef IF_FETCH_COUNT_EN
    chk("model fetch_count", fetch_count, m_cnt);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h8C01_0000;
    mem[1] = 32'h8C02_0001;
    mem[2] = 32'h0022_1820;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
    clear_inputs();
    rst = 1;

    // Reset held two cycles
    tick(); tick();
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset valid", {31'b0, if_id_valid}, 32'h0);
    chk("reset instr", if_id_instr, 32'h0);
    chk("reset pc4", if_id_pc4, 32'h0);

    // Free-running fetch of the preloaded program
    rst = 0;
    tick();
    chk("seq0 instr", if_id_instr, 32'h8C01_0000);
    chk("seq0 pc4", if_id_pc4, 32'h4);
    chk("seq0 addr", imem_addr, 32'h4);
    tick();
    chk("seq1 instr", if_id_instr, 32'h8C02_0001);
    chk("seq1 addr", imem_addr, 32'h8);

    // Two stall cycles at PC=8
    stall = 1;
    tick(); tick();
    chk("stall addr", imem_addr, 32'h8);
    chk("stall instr", if_id_instr, 32'h8C02_0001);
    chk("stall pc4", if_id_pc4, 32'h8);
    stall = 0;
    tick();
    chk("resume instr", if_id_instr, 32'h0022_1820);
    chk("resume addr", imem_addr, 32'hC);

    // Branch + jump + stall together: branch wins
    branch_taken = 1; jump = 1; stall = 1;
    branch_target = 32'h20; jump_index = 26'h3FF_FFFF;
    tick();
    chk("bj addr", imem_addr, 32'h20);
    chk("bj valid", {31'b0, if_id_valid}, 32'h0);
    chk("bj instr", if_id_instr, 32'h0);
    clear_inputs();
    tick();
    chk("after branch pc4", if_id_pc4, 32'h24);

    // Jump using region of if_id_pc4 = 0x24
    jump = 1; jump_index = 26'h18;
    tick();
    chk("jump addr", imem_addr, 32'h60);
    chk("jump valid", {31'b0, if_id_valid}, 32'h0);
    clear_inputs();
    tick();
    chk("post jump valid", {31'b0, if_id_valid}, 32'h1);
    chk("post jump pc4", if_id_pc4, 32'h64);

    // PC wraps from the top of the address space
    branch_taken = 1; branch_target = 32'hFFFF_FFFE;
    tick();
    chk("wrap branch addr", imem_addr, 32'hFFFF_FFFC);
    clear_inputs();
    tick();
    chk("wrap addr", imem_addr, 32'h0);
    chk("wrap pc4", if_id_pc4, 32'h0);
    chk("wrap valid", {31'b0, if_id_valid}, 32'h1);
    chk("wrap instr", if_id_instr, mem[255]);

    // Flush alone advances PC; flush with stall holds PC
    flush = 1;
    tick();
    chk("flush addr", imem_addr, 32'h4);
    chk("flush valid", {31'b0, if_id_valid}, 32'h0);
    stall = 1;
    tick();
    chk("flush+stall addr", imem_addr, 32'h4);
    clear_inputs();

`ifdef IF_FETCH_COUNT_EN
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 5; i++) tick();
    flush = 1; tick(); flush = 0;
    stall = 1; tick(); tick(); stall = 0;
    chk("count five", fetch_count, 32'd5);
    rst = 1; tick(); rst = 0;
    chk("count reset", fetch_count, 32'd0);
`endif

    // Random stimulus, including occasional mid-sequence reset
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      branch_target = $urandom;
      jump_index    = 26'($urandom);
      tick();
    end
    rst = 0; clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall  input  1  hold the PC and the IF/ID register (load-use hazard).
REQ-005 SHALL have port flush  input  1  force a bubble into IF/ID on the next edge.
REQ-006 SHALL have port branch_taken  input  1  redirect the PC to branch_target.
REQ-007 SHALL have port branch_target  input  32  byte address of the branch destination.
REQ-008 SHALL have port jump  input  1  redirect the PC to the J-type target.
REQ-009 SHALL have port jump_index  input  26  J-type instr_index field.
REQ-010 SHALL have port imem_addr  output  32  byte address to instruction memory (memory indexes by address>>2).
REQ-011 SHALL have port imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-012 SHALL have port if_id_instr  output  32  registered instruction for decode.
REQ-013 SHALL have port if_id_pc4  output  32  registered PC+4 of if_id_instr.
REQ-014 SHALL have port if_id_valid  output  1  if_id_instr is a real fetched instruction, not a bubble.

Function
REQ-015 SHALL hold a 32-bit PC register and drive imem_addr = PC combinationally, with zero added latency.
REQ-016 SHALL select next PC by priority: rst > branch_taken > jump > stall > PC+4.
REQ-017 SHALL compute the branch target as {branch_target[31:2], 2'b00}.
REQ-018 SHALL compute the jump target as {if_id_pc4[31:28], jump_index, 2'b00}.
REQ-019 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC + 4 -> 0), with no error flag.
REQ-020 SHALL load IF/ID normally: if_id_instr <= imem_instr, if_id_pc4 <= PC+4, if_id_valid <= 1.
REQ-021 SHALL, when stall=1 with no redirect and no flush, hold the PC and all IF/ID outputs unchanged.
REQ-022 SHALL treat branch_taken or jump as an implicit flush: the PC is redirected and IF/ID loads a bubble.
REQ-023 SHALL define a bubble as if_id_instr=32'h0 (sll $0 nop), if_id_pc4=32'h0, if_id_valid=0.
REQ-024 SHALL let flush override stall for IF/ID, and a redirect override stall for the PC.
REQ-025 SHALL, on branch_taken and jump in the same cycle, take the branch and ignore the jump.
REQ-026 SHALL place the first instruction in IF/ID one cycle after PC changes; fetch-to-decode latency is 1 cycle.

Reset
REQ-027 SHALL, on a clock edge with rst=1, set PC=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0.
REQ-028 SHALL let reset override stall, flush and redirects asserted in the same cycle, including mid-sequence.
REQ-029 SHALL resume sequential fetch at RESET_PC on the first edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro IF_FETCH_COUNT_EN defined, add output fetch_count (32 bits).
REQ-031 SHALL, with IF_FETCH_COUNT_EN defined, increment fetch_count on each edge that loads if_id_valid=1 from a real fetch, clear it on reset, and wrap from 32'hFFFF_FFFF to 0.
REQ-032 SHALL, without IF_FETCH_COUNT_EN, omit the fetch_count port and its logic, leaving all other behaviour identical.

Verification
REQ-033 SHALL cover: rst high 2 cycles, then released -> imem_addr=0, if_id_valid=0 during reset; the next edge gives if_id_instr=mem[0], if_id_pc4=4.
REQ-034 SHALL cover: memory preloaded 8C010000, 8C020001, 00221820, with 3 free-running cycles -> if_id_instr follows that sequence and imem_addr goes 0, 4, 8, C.
REQ-035 SHALL cover: stall high 2 cycles at PC=8 -> imem_addr stays 8, IF/ID held, and fetch resumes at C afterwards.
REQ-036 SHALL cover: jump=1, jump_index=26'h18, if_id_pc4=0x24 -> next imem_addr=0x60, if_id_valid=0 for one cycle.
REQ-037 SHALL cover: branch_taken=1, jump=1, branch_target=0x20 and stall=1 all together -> imem_addr=0x20 and a bubble in IF/ID.
REQ-038 SHALL cover, with IF_FETCH_COUNT_EN: 5 valid fetches, 1 flush, 2 stall cycles -> fetch_count=5, and rst clears it to 0.
